// File: rtl/sqw_pkg.sv
// Shared types for the square-wave step sequencer.
// Holds the FSM state enum, default field widths and the step record.
package sqw_pkg;

    localparam int SQW_CNT_W = 16;
    localparam int SQW_REP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    // One table entry; "repeat" is a keyword, hence "rep".
    typedef struct packed {
        logic [SQW_CNT_W-1:0] half_period;
        logic [SQW_REP_W-1:0] rep;
    } step_t;

endpackage

// File: rtl/sqw_tone_counter.sv
// Half-period counter and out1 toggle flop for one sequencer step.
// Ports: clk, rst_n, hp (half-period), enable, clear -> out1, out1_rise, out1_fall.
module sqw_tone_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] hp,
    input  logic             enable,
    input  logic             clear,
    output logic             out1,
    output logic             out1_rise,
    output logic             out1_fall
);

    logic [CNT_W-1:0] half_cnt_q;
    logic             out1_q;
    logic             tick;

    // tick marks the edge on which out1 toggles; rise/fall tell the
    // sequencer which direction that toggle goes before it happens.
    assign tick      = enable && !clear && (half_cnt_q == hp - CNT_W'(1));
    assign out1_rise = tick && !out1_q;
    assign out1_fall = tick && out1_q;
    assign out1      = out1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            out1_q     <= 1'b0;
        end else if (clear) begin
            half_cnt_q <= '0;
            out1_q     <= 1'b0;
        end else if (enable) begin
            if (tick) begin
                half_cnt_q <= '0;
                out1_q     <= !out1_q;
            end else begin
                half_cnt_q <= half_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/square_wave_sequencer.sv
// Walks a small step table, driving out1 at each step's rate and out2 at half that.
// Ports: clk, reset(n), start, stop, cfg_* table write -> busy, done, step_idx, out1, out2.
module square_wave_sequencer
    import sqw_pkg::*;
#(
    parameter int CNT_W     = SQW_CNT_W,
    parameter int REP_W     = SQW_REP_W,
    parameter int NUM_STEPS = 4,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] step_idx,
    output logic             out1,
    output logic             out2
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] per_q, per_d;
    logic             out2_q, out2_d;
    logic             busy_q, done_q;
    step_t            tab_q [NUM_STEPS];
    step_t            cur;
    logic             tab_we;
    logic             tone_en, tone_clr;
    logic             rise, fall;

    assign cur    = tab_q[idx_q];
    assign tab_we = cfg_we && (state_q == S_IDLE || state_q == S_DONE);

    assign tone_en  = (state_q == S_RUN);
    assign tone_clr = (state_q != S_RUN) || stop;

    sqw_tone_counter #(
        .CNT_W(CNT_W)
    ) u_tone (
        .clk      (clk),
        .rst_n    (reset),
        .hp       (hp_q),
        .enable   (tone_en),
        .clear    (tone_clr),
        .out1     (out1),
        .out1_rise(rise),
        .out1_fall(fall)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hp_d    = hp_q;
        rep_d   = rep_q;
        per_d   = per_q;
        out2_d  = out2_q;
        unique case (state_q)
            S_IDLE: begin
                out2_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                hp_d  = cur.half_period;
                rep_d = cur.rep;
                per_d = '0;
                // A zero field in either half skips the step entirely.
                if (cur.half_period == '0 || cur.rep == '0) begin
                    if (idx_q == LAST) state_d = S_DONE;
                    else idx_d = idx_q + 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rise) out2_d = !out2_q;
                if (fall) begin
                    per_d = per_q + 1'b1;
                    if (per_d == rep_q) begin
                        if (idx_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                            idx_d   = idx_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                out2_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides whatever the state wanted to do.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            hp_d    = '0;
            rep_d   = '0;
            per_d   = '0;
            out2_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hp_q    <= '0;
            rep_q   <= '0;
            per_q   <= '0;
            out2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) tab_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hp_q    <= hp_d;
            rep_q   <= rep_d;
            per_q   <= per_d;
            out2_q  <= out2_d;
            busy_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
            if (tab_we) begin
                tab_q[cfg_addr] <= '{half_period: cfg_half_period, rep: cfg_repeat};
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;
    assign out2     = out2_q;

endmodule

// File: tb/tb_square_wave_sequencer.sv
// Self-checking bench for square_wave_sequencer.
// Expected waveforms come from a per-cycle model built from the step table.
module tb_square_wave_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_half_period;
    logic [7:0]  cfg_repeat;
    logic        busy;
    logic        done;
    logic [1:0]  step_idx;
    logic        out1;
    logic        out2;

    int n_assert = 0;
    int n_fail   = 0;

    int m_hp  [4];
    int m_rep [4];

    typedef struct {
        logic       busy;
        logic       done;
        logic [1:0] idx;
        logic       o1;
        logic       o2;
        bit         chk_idx;
    } exp_t;

    exp_t exp_q[$];
    int   done_at;
    int   o2_toggles;

    always #5 clk = ~clk;

    square_wave_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_half_period(cfg_half_period),
        .cfg_repeat     (cfg_repeat),
        .busy           (busy),
        .done           (done),
        .step_idx       (step_idx),
        .out1           (out1),
        .out2           (out2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".idx"}, step_idx, 0);
        chk({tag, ".out1"}, out1, 0);
        chk({tag, ".out2"}, out2, 0);
    endtask

    task automatic wr(input int a, input int hp, input int rep);
        cfg_we          = 1'b1;
        cfg_addr        = 2'(a);
        cfg_half_period = 16'(hp);
        cfg_repeat      = 8'(rep);
        @(negedge clk);
        cfg_we = 1'b0;
        m_hp[a]  = hp;
        m_rep[a] = rep;
    endtask

    // One entry per clock after the start edge: LOAD, RUN..., DONE, IDLE.
    task automatic build_exp();
        int rises;
        exp_t e;
        rises = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            e = '{1'b1, 1'b0, 2'(i), 1'b0, 1'(rises % 2), 1'b1};
            exp_q.push_back(e);
            if (m_hp[i] != 0 && m_rep[i] != 0) begin
                for (int c = 0; c < 2 * m_hp[i] * m_rep[i]; c++) begin
                    e.o1 = 1'((c / m_hp[i]) % 2);
                    e.o2 = 1'((rises + (c / m_hp[i] + 1) / 2) % 2);
                    exp_q.push_back(e);
                end
                rises += m_rep[i];
            end
        end
        e = '{1'b0, 1'b1, 2'd0, 1'b0, 1'(rises % 2), 1'b0};
        exp_q.push_back(e);
        e = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic run_seq(input string name, input int stop_at,
                           input bit noise, input bit wr_start,
                           input int whp, input int wrep);
        logic prev_o2;
        string t;
        start = 1'b1;
        if (wr_start) begin
            cfg_we          = 1'b1;
            cfg_addr        = 2'd0;
            cfg_half_period = 16'(whp);
            cfg_repeat      = 8'(wrep);
            m_hp[0]  = whp;
            m_rep[0] = wrep;
        end
        build_exp();
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        done_at    = -1;
        o2_toggles = 0;
        prev_o2    = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            t = $sformatf("%s.k%0d", name, k);
            chk({t, ".busy"}, busy, exp_q[k].busy);
            chk({t, ".done"}, done, exp_q[k].done);
            chk({t, ".out1"}, out1, exp_q[k].o1);
            chk({t, ".out2"}, out2, exp_q[k].o2);
            if (exp_q[k].chk_idx) chk({t, ".idx"}, step_idx, exp_q[k].idx);
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (exp_q[k].busy || exp_q[k].done) begin
                if (out2 !== prev_o2) o2_toggles++;
                prev_o2 = out2;
            end
            if (k == stop_at) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk_idle({name, ".stopped"});
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk_idle($sformatf("%s.after_stop%0d", name, j));
                end
                return;
            end
            if (noise && k >= 1 && k <= 3) begin
                cfg_we          = 1'b1;
                cfg_addr        = 2'd0;
                cfg_half_period = 16'd9;
                cfg_repeat      = 8'd9;
                start           = 1'b1;
            end else begin
                cfg_we = 1'b0;
                start  = 1'b0;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_half_period = '0;
        cfg_repeat = '0;
        for (int i = 0; i < 4; i++) begin
            m_hp[i]  = 0;
            m_rep[i] = 0;
        end
        repeat (4) @(negedge clk);
        chk_idle("in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // Cleared table: every step skipped.
        run_seq("empty", -1, 1'b0, 1'b0, 0, 0);

        // Single step {2,3}.
        wr(0, 2, 3);
        run_seq("single", -1, 1'b0, 1'b0, 0, 0);
        chk("single.done_at", done_at, 16);
        chk("single.o2_tog", o2_toggles, 3);

        // Full four-step sequence.
        wr(0, 1, 2);
        wr(1, 3, 1);
        wr(2, 5, 2);
        wr(3, 2, 4);
        run_seq("full", -1, 1'b0, 1'b0, 0, 0);
        chk("full.done_at", done_at, 50);
        chk("full.o2_tog", o2_toggles, 9);

        // Stop mid-RUN, then restart from step 0.
        wr(0, 4, 10);
        wr(1, 0, 0);
        wr(2, 0, 0);
        wr(3, 0, 0);
        run_seq("stop", 20, 1'b0, 1'b0, 0, 0);
        wr(0, 2, 2);
        run_seq("restart", -1, 1'b0, 1'b0, 0, 0);

        // Writes and start while busy are ignored.
        wr(0, 3, 2);
        wr(2, 1, 1);
        run_seq("lock", -1, 1'b1, 1'b0, 0, 0);
        run_seq("lock2", -1, 1'b0, 1'b0, 0, 0);

        // start+stop together in IDLE does nothing.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("ss0");
        @(negedge clk);
        chk_idle("ss1");

        // Write on the start cycle is used by the run.
        run_seq("wr_start", -1, 1'b0, 1'b1, 2, 1);

        // Random tables.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                wr(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
            run_seq($sformatf("rnd%0d", r), -1, 1'($urandom_range(0, 1)),
                    1'b0, 0, 0);
        end

        // Async reset mid-RUN acts without a clock edge.
        wr(0, 4, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst.pre_out1", out1, 1);
        chk("arst.pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("arst.now");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_hp[i]  = 0;
            m_rep[i] = 0;
        end
        @(negedge clk);
        chk_idle("arst.rel");
        run_seq("arst.empty", -1, 1'b0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
